// File: rtl/stack_seq_ctrl_if.sv
// stack_seq_ctrl_if: decode/datapath/memory handshake bundle for the stack sequencer
interface stack_seq_ctrl_if #(parameter int WIDTH = 16);
  logic             op_valid;
  logic [1:0]       op_code;
  logic             op_ready;
  logic [WIDTH-1:0] sp_in;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             sp_inc;
  logic             sp_dec;
  logic             src_oe;
  logic             pc_oe;
  logic             tgt_oe;
  logic             mem_oe;
  logic             pc_load;
  logic             dst_load;
  logic             done;
  logic [1:0]       err_code;
  modport master (
    output op_valid, op_code, sp_in, mem_ack,
    input  op_ready, mem_addr, mem_req, mem_we, sp_inc, sp_dec, src_oe, pc_oe,
           tgt_oe, mem_oe, pc_load, dst_load, done, err_code
  );
  modport slave (
    input  op_valid, op_code, sp_in, mem_ack,
    output op_ready, mem_addr, mem_req, mem_we, sp_inc, sp_dec, src_oe, pc_oe,
           tgt_oe, mem_oe, pc_load, dst_load, done, err_code
  );
endinterface

// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: PUSH/POP/CALL/RET sequencer driving SP strobes, bus enables and memory handshake
module stack_seq_ctrl #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] STACK_BASE  = '0,
  parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(16'hF000),
  parameter int               ACK_TIMEOUT = 15
) (
  input logic             clk,
  input logic             clr,
  stack_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11;
  localparam logic [1:0] ERR_OK = 2'b00, ERR_OVF = 2'b01, ERR_UDF = 2'b10, ERR_TMO = 2'b11;
  typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC, JMP, FIX, DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, waiting, tmo, full, empty;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= OP_PUSH;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Counter is zero in every non-wait state, so it starts clean on each WR/RD entry
  always_comb begin
    accept  = bus.op_valid & (state_q == IDLE);
    waiting = (state_q == WR) | (state_q == RD);
    tmo     = waiting & ~bus.mem_ack & (cnt_q == CW'(ACK_TIMEOUT - 1));
    full    = bus.sp_in == STACK_LIMIT;
    empty   = bus.sp_in == STACK_BASE;
    cnt_d   = waiting ? cnt_q + CW'(1) : '0;
    op_d    = accept ? bus.op_code : op_q;
    err_d   = err_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = bus.op_code[0] ? (empty ? DONE : RD) : (full ? DONE : DEC);
        err_d   = bus.op_code[0] ? (empty ? ERR_UDF : ERR_OK) : (full ? ERR_OVF : ERR_OK);
      end
      DEC:  state_d = WR;
      WR:   state_d = bus.mem_ack ? ((op_q == OP_CALL) ? JMP : DONE) : (tmo ? FIX : WR);
      RD: begin
        state_d = bus.mem_ack ? INC : (tmo ? DONE : RD);
        err_d   = tmo ? ERR_TMO : err_q;
      end
      INC:  state_d = DONE;
      JMP:  state_d = DONE;
      FIX: begin
        state_d = DONE;
        err_d   = ERR_TMO;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.op_ready = state_q == IDLE;
  assign bus.mem_addr = bus.sp_in;
  assign bus.mem_req  = waiting;
  assign bus.mem_we   = state_q == WR;
  assign bus.sp_dec   = state_q == DEC;
  assign bus.sp_inc   = (state_q == INC) | (state_q == FIX);
  assign bus.src_oe   = (state_q == WR) & (op_q == OP_PUSH);
  assign bus.pc_oe    = (state_q == WR) & (op_q == OP_CALL);
  assign bus.tgt_oe   = state_q == JMP;
  assign bus.mem_oe   = state_q == RD;
  assign bus.pc_load  = (state_q == JMP) | ((state_q == RD) & bus.mem_ack & (op_q == OP_RET));
  assign bus.dst_load = (state_q == RD) & bus.mem_ack & (op_q == OP_POP);
  assign bus.done     = state_q == DONE;
  assign bus.err_code = (state_q == DONE) ? err_q : ERR_OK;
endmodule

// File: tb/tb_stack_seq_ctrl.sv
// tb_stack_seq_ctrl: table-driven scoreboard bench with an SP register model updating on falling clk
module tb_stack_seq_ctrl;
  typedef struct {
    logic [1:0]  op;
    logic [15:0] sp0;
    int          wt;
    logic [1:0]  err;
    int          lat;
    logic [15:0] spf;
    int          dec;
    int          inc;
    int          ld;
    int          req;
  } vec_t;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        sp_set = 1'b0;
  logic [15:0] sp_val = 16'h0000;
  logic [15:0] sp = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[12];
  vec_t        exp_q[$];
  always #5 clk = ~clk;
  stack_seq_ctrl_if #(.WIDTH(16)) bus();
  stack_seq_ctrl #(
    .WIDTH(16), .STACK_BASE(16'h0000), .STACK_LIMIT(16'hF000), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus.slave)
  );
  assign bus.sp_in = sp;
  always @(negedge clk)
    sp <= sp_set ? sp_val : sp + {15'd0, bus.sp_inc} - {15'd0, bus.sp_dec};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic load_sp(input logic [15:0] v);
    sp_val = v;
    sp_set = 1'b1;
    @(negedge clk);
    #1 sp_set = 1'b0;
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, dec, inc, ld, req, waited, bad;
    logic [1:0] err;
    logic got;
    vec_t e;
    dec = 0; inc = 0; ld = 0; req = 0; waited = 0; bad = 0; got = 1'b0; err = 2'b00;
    load_sp(v.sp0);
    bus.op_code = v.op;
    bus.op_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1 bus.op_code = ~v.op;
    for (cyc = 1; cyc <= 100; cyc++) begin
      bus.mem_ack = bus.mem_req && (v.wt >= 0) && (waited == v.wt);
      if (bus.mem_req && !bus.mem_ack) waited++;
      #1;
      dec += int'(bus.sp_dec);
      inc += int'(bus.sp_inc);
      ld  += int'(bus.pc_load) + int'(bus.dst_load);
      req += int'(bus.mem_req);
      if (bus.mem_addr !== sp) bad++;
      if (int'(bus.src_oe) + int'(bus.pc_oe) + int'(bus.tgt_oe) + int'(bus.mem_oe) > 1) bad++;
      if (bus.sp_inc && bus.sp_dec) bad++;
      if (bus.op_ready) bad++;
      if (!bus.done && bus.err_code != 2'b00) bad++;
      if (bus.mem_req && (bus.mem_we != !v.op[0])) bad++;
      if (bus.src_oe !== (bus.mem_req && bus.mem_we && v.op == 2'b00)) bad++;
      if (bus.pc_oe !== (bus.mem_req && bus.mem_we && v.op == 2'b10)) bad++;
      if (bus.mem_oe !== (bus.mem_req && !bus.mem_we)) bad++;
      if (bus.dst_load !== (bus.mem_oe && bus.mem_ack && v.op == 2'b01)) bad++;
      if (bus.done) begin
        got = 1'b1;
        err = bus.err_code;
        bus.op_valid = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0;
    bus.op_valid = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
    if (exp_q.size() == 0) chk($sformatf("v%0d_sb_nonempty", idx), 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_err", idx), 32'(err), 32'(e.err));
      chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(e.lat));
      chk($sformatf("v%0d_sp_final", idx), 32'(sp), 32'(e.spf));
      chk($sformatf("v%0d_sp_dec_cnt", idx), 32'(dec), 32'(e.dec));
      chk($sformatf("v%0d_sp_inc_cnt", idx), 32'(inc), 32'(e.inc));
      chk($sformatf("v%0d_load_cnt", idx), 32'(ld), 32'(e.ld));
      chk($sformatf("v%0d_req_cycles", idx), 32'(req), 32'(e.req));
      chk($sformatf("v%0d_protocol_viol", idx), 32'(bad), 32'd0);
    end
    @(posedge clk);
    #1 chk($sformatf("v%0d_idle_after", idx), {31'd0, bus.op_ready}, 32'd1);
  endtask
  initial begin
    //            op     sp0       wt  err    lat spf       dec inc ld req
    vecs[0]  = '{2'b00, 16'h0000,  0, 2'b00,  3, 16'hFFFF, 1, 0, 0, 1};
    vecs[1]  = '{2'b01, 16'hFFFF,  2, 2'b00,  5, 16'h0000, 0, 1, 1, 3};
    vecs[2]  = '{2'b10, 16'h1000,  0, 2'b00,  4, 16'h0FFF, 1, 0, 1, 1};
    vecs[3]  = '{2'b11, 16'h0FFF,  0, 2'b00,  3, 16'h1000, 0, 1, 1, 1};
    vecs[4]  = '{2'b00, 16'hF000,  0, 2'b01,  1, 16'hF000, 0, 0, 0, 0};
    vecs[5]  = '{2'b10, 16'hF000,  0, 2'b01,  1, 16'hF000, 0, 0, 0, 0};
    vecs[6]  = '{2'b01, 16'h0000,  0, 2'b10,  1, 16'h0000, 0, 0, 0, 0};
    vecs[7]  = '{2'b11, 16'h0000,  0, 2'b10,  1, 16'h0000, 0, 0, 0, 0};
    vecs[8]  = '{2'b00, 16'h1234, -1, 2'b11, 18, 16'h1234, 1, 1, 0, 15};
    vecs[9]  = '{2'b01, 16'h8000, -1, 2'b11, 16, 16'h8000, 0, 0, 0, 15};
    vecs[10] = '{2'b00, 16'hF001, 14, 2'b00, 17, 16'hF000, 1, 0, 0, 15};
    vecs[11] = '{2'b10, 16'h0001,  1, 2'b00,  5, 16'h0000, 1, 0, 1, 2};
    bus.op_valid = 1'b0;
    bus.op_code = 2'b00;
    bus.mem_ack = 1'b0;
    load_sp(16'hABCD);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs", {18'd0, bus.op_ready, bus.mem_req, bus.mem_we, bus.sp_inc, bus.sp_dec,
        bus.src_oe, bus.pc_oe, bus.tgt_oe, bus.mem_oe, bus.pc_load, bus.dst_load, bus.done,
        bus.err_code}, {18'd0, 14'b10_0000_0000_0000});
    chk("reset_mem_addr", {16'd0, bus.mem_addr}, 32'h0000ABCD);
    clr = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    load_sp(16'h1000);
    bus.op_code = 2'b10;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("clr_wr_pc_oe", {30'd0, bus.pc_oe, bus.mem_req}, 32'd3);
    chk("clr_wr_addr", {16'd0, bus.mem_addr}, 32'h00000FFF);
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clr_strobes_%0d", k), {20'd0, bus.mem_req, bus.sp_inc, bus.sp_dec, bus.src_oe,
          bus.pc_oe, bus.tgt_oe, bus.mem_oe, bus.pc_load, bus.dst_load, bus.done, bus.err_code}, 32'd0);
      chk($sformatf("clr_op_ready_%0d", k), {31'd0, bus.op_ready}, 32'd1);
    end
    bus.op_valid = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    run_vec(12, vecs[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
